// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter: shares the register-file write port between MEM/WB and a multi-cycle unit,
// forcing a one-cycle pipe stall after STARVE_LIMIT blocked cycles. Option: WB_ARB_STATS_EN. Rev 1.0
// ============================================================================
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_regwrite,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            mc_valid,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_wdata,
  output logic            mc_ready,
  output logic            pipe_stall,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]     stat_mc_grants,
  output logic [31:0]     stat_force_stalls
`endif
);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE  = 1'b1;
  localparam logic [3:0] LIMIT_M1  = 4'(STARVE_LIMIT - 1);

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [3:0]      starve_cnt;
  logic [3:0]      starve_cnt_nxt;
  logic            pipe_live;
  logic            grant_pipe;
  logic            mc_grant;
  logic            mc_accept;
  logic            blocked;
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_wdata;

  assign pipe_live = pipe_regwrite && (pipe_rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_NORMAL: if (blocked && (starve_cnt == LIMIT_M1)) state_nxt = ST_FORCE;
      ST_FORCE:  state_nxt = ST_NORMAL;
      default:   state_nxt = ST_NORMAL;
    endcase
  end

  always_comb begin
    pipe_stall = 1'b0;
    grant_pipe = 1'b0;
    mc_grant   = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (pipe_live) grant_pipe = 1'b1;
        else           mc_grant   = mc_valid;
      end
      ST_FORCE: begin
        pipe_stall = 1'b1;
        mc_grant   = mc_valid;
      end
      default: ;
    endcase
  end

  // mc_ready is gated directly by reset so a waiting unit never sees an accept during reset
  assign mc_ready  = mc_grant & reset;
  assign mc_accept = mc_valid & mc_grant;
  assign blocked   = mc_valid & ~mc_grant;

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if ((state == ST_FORCE) || mc_accept) begin
      starve_cnt_nxt = 4'd0;
    end else if (blocked) begin
      starve_cnt_nxt = (starve_cnt == LIMIT_M1) ? 4'd0 : starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // mc results addressed to x0 are accepted but never written
  assign wr_en    = grant_pipe | (mc_accept & (mc_rd != 5'd0));
  assign wr_rd    = grant_pipe ? pipe_rd : mc_rd;
  assign wr_wdata = grant_pipe ? pipe_wdata : mc_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_rd    <= wr_rd;
        rf_wdata <= wr_wdata;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_mc_grants    <= 32'd0;
      stat_force_stalls <= 32'd0;
    end else begin
      if (mc_accept)         stat_mc_grants    <= stat_mc_grants + 32'd1;
      if (state == ST_FORCE) stat_force_stalls <= stat_force_stalls + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a queue-free
// behavioural model of the arbitration rules. Rev 1.0
// ============================================================================
module tb_wb_port_arbiter;
  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            pipe_regwrite = 1'b0;
  logic [4:0]      pipe_rd = 5'd0;
  logic [XLEN-1:0] pipe_wdata = '0;
  logic            mc_valid = 1'b0;
  logic [4:0]      mc_rd = 5'd0;
  logic [XLEN-1:0] mc_wdata = '0;
  logic            mc_ready;
  logic            pipe_stall;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
  logic [31:0]     stat_mc_grants;
  logic [31:0]     stat_force_stalls;
`endif

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_regwrite(pipe_regwrite), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
`ifdef WB_ARB_STATS_EN
    , .stat_mc_grants(stat_mc_grants), .stat_force_stalls(stat_force_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: forcing flag, length of the current blocked run, expected register-file port
  bit          m_force;
  int          m_run;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_wd;
  int unsigned m_grants;
  int unsigned m_forces;
  bit          m_accepted;
  bit          m_was_force;

  function automatic bit exp_ready();
    if (!reset) return 1'b0;
    if (m_force) return mc_valid;
    if (pipe_regwrite && pipe_rd != 5'd0) return 1'b0;
    return mc_valid;
  endfunction

  task automatic model_reset();
    m_force = 0; m_run = 0; m_we = 0; m_rd = '0; m_wd = '0;
    m_grants = 0; m_forces = 0; m_accepted = 0; m_was_force = 0;
  endtask

  task automatic model_edge();
    bit live;
    bit take;
    live        = pipe_regwrite && (pipe_rd != 5'd0);
    take        = mc_valid && (m_force || !live);
    m_was_force = m_force;
    m_accepted  = take;
    if (m_force) begin
      m_forces++;
      m_force = 0;
      m_run   = 0;
    end else if (mc_valid && !take) begin
      m_run++;
      if (m_run == LIMIT) begin
        m_force = 1;
        m_run   = 0;
      end
    end else if (take) begin
      m_run = 0;
    end
    if (take) m_grants++;
    if (take && mc_rd != 5'd0) begin
      m_we = 1; m_rd = mc_rd; m_wd = mc_wdata;
    end else if (!m_was_force && live) begin
      m_we = 1; m_rd = pipe_rd; m_wd = pipe_wdata;
    end else begin
      m_we = 0;
    end
  endtask

  always @(negedge clk) begin
    chk("mc_ready", {63'd0, mc_ready}, {63'd0, exp_ready()});
    chk("pipe_stall", {63'd0, pipe_stall}, {63'd0, m_force});
    chk("rf_we", {63'd0, rf_we}, {63'd0, m_we});
    chk("rf_rd", {59'd0, rf_rd}, {59'd0, m_rd});
    chk("rf_wdata", rf_wdata, m_wd);
`ifdef WB_ARB_STATS_EN
    chk("stat_mc_grants", {32'd0, stat_mc_grants}, {32'd0, m_grants});
    chk("stat_force_stalls", {32'd0, stat_force_stalls}, {32'd0, m_forces});
`endif
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_stall", {63'd0, pipe_stall}, 64'd0);
    chk("rst_we", {63'd0, rf_we}, 64'd0);
    chk("rst_ready", {63'd0, mc_ready}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    chk("rst_rd", {59'd0, rf_rd}, 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);

    // plain pipe write
    pipe_regwrite = 1; pipe_rd = 5'd5; pipe_wdata = 64'hAA;
    tick();
    chk("pipe_we", {63'd0, rf_we}, 64'd1);
    chk("pipe_rd", {59'd0, rf_rd}, 64'd5);
    chk("pipe_wd", rf_wdata, 64'hAA);

    // pipe targets x0, so the mc result goes straight through
    pipe_rd = 5'd0; mc_valid = 1; mc_rd = 5'd7; mc_wdata = 64'h1234;
    #1;
    chk("mc_ready_x0pipe", {63'd0, mc_ready}, 64'd1);
    tick();
    chk("mc_rd", {59'd0, rf_rd}, 64'd7);
    chk("mc_wd", rf_wdata, 64'h1234);

    // mc result to x0: accepted, discarded, port held
    pipe_regwrite = 0; mc_rd = 5'd0; mc_wdata = 64'h55;
    #1;
    chk("mc_x0_ready", {63'd0, mc_ready}, 64'd1);
    tick();
    chk("mc_x0_we", {63'd0, rf_we}, 64'd0);
    chk("mc_x0_hold", {59'd0, rf_rd}, 64'd7);
    mc_valid = 0;

    // starvation: four blocked cycles, one forced grant, then the held pipe write
    tick();
    do_reset();
`ifdef WB_ARB_STATS_EN
    chk("stat_grants_rst", {32'd0, stat_mc_grants}, 64'd0);
`endif
    pipe_regwrite = 1; pipe_rd = 5'd3; pipe_wdata = 64'h30;
    mc_valid = 1; mc_rd = 5'd9; mc_wdata = 64'h99;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      chk("blk_ready", {63'd0, mc_ready}, 64'd0);
      chk("blk_stall", {63'd0, pipe_stall}, 64'd0);
      tick();
      chk("blk_pipe_rd", {59'd0, rf_rd}, 64'(3 + i));
      pipe_rd = 5'(4 + i); pipe_wdata = 64'(pipe_rd) * 64'h10;
    end
    #1;
    chk("force_stall", {63'd0, pipe_stall}, 64'd1);
    chk("force_ready", {63'd0, mc_ready}, 64'd1);
    tick();
    chk("force_rd", {59'd0, rf_rd}, 64'd9);
    chk("force_wd", rf_wdata, 64'h99);
    mc_valid = 0;
    #1;
    chk("after_force_stall", {63'd0, pipe_stall}, 64'd0);
    tick();
    chk("held_we", {63'd0, rf_we}, 64'd1);
    chk("held_rd", {59'd0, rf_rd}, 64'd7);
    chk("held_wd", rf_wdata, 64'h70);
`ifdef WB_ARB_STATS_EN
    chk("stat_force", {32'd0, stat_force_stalls}, 64'd1);
    chk("stat_grants", {32'd0, stat_mc_grants}, 64'd1);
`endif

    // reset in the middle of a forced cycle, then normal re-arbitration
    pipe_rd = 5'd4; pipe_wdata = 64'h44;
    mc_valid = 1; mc_rd = 5'd12; mc_wdata = 64'hC12;
    for (int i = 0; i < LIMIT; i++) tick();
    #1;
    chk("pre_rst_stall", {63'd0, pipe_stall}, 64'd1);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_stall", {63'd0, pipe_stall}, 64'd0);
    chk("midrst_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_ready", {63'd0, mc_ready}, 64'd0);
    tick();
    tick();
    reset = 1'b1; pipe_regwrite = 0;
    #1;
    chk("rearb_ready", {63'd0, mc_ready}, 64'd1);
    tick();
    chk("rearb_we", {63'd0, rf_we}, 64'd1);
    chk("rearb_rd", {59'd0, rf_rd}, 64'd12);
    chk("rearb_wd", rf_wdata, 64'hC12);
    mc_valid = 0;

    // randomized traffic; pipe held while stalled, mc held until accepted
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 700 == 699) do_reset();
      if (m_force && mc_valid && $urandom_range(0, 7) == 0) begin
        mc_valid = 0;
      end else if (!mc_valid || m_accepted) begin
        mc_valid = ($urandom_range(0, 99) < 45);
        mc_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        mc_wdata = {$urandom, $urandom};
      end
      if (!m_was_force) begin
        pipe_regwrite = ($urandom_range(0, 99) < 75);
        pipe_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        pipe_wdata    = {$urandom, $urandom};
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64: register-file data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, legal range 1..15: consecutive blocked cycles before a forced grant.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous reset, active-low.
REQ-005 SHALL have port pipe_regwrite, input, 1: write request from the MEM/WB stage.
REQ-006 SHALL have port pipe_rd, input, 5: MEM/WB destination register.
REQ-007 SHALL have port pipe_wdata, input, XLEN: MEM/WB writeback data, already selected between memory and ALU.
REQ-008 SHALL have port mc_valid, input, 1: multi-cycle unit (mul/div) result valid.
REQ-009 SHALL have port mc_rd, input, 5: multi-cycle result destination register.
REQ-010 SHALL have port mc_wdata, input, XLEN: multi-cycle result data.
REQ-011 SHALL have port mc_ready, output, 1: multi-cycle result accepted this cycle.
REQ-012 SHALL have port pipe_stall, output, 1: freeze MEM/WB and all upstream stages this cycle.
REQ-013 SHALL have ports rf_we (output, 1), rf_rd (output, 5) and rf_wdata (output, XLEN): registered register-file write port.

Function
REQ-014 SHALL treat a pipe request as a live write only when pipe_regwrite=1 and pipe_rd!=0.
REQ-015 SHALL use a two-state FSM: NORMAL and FORCE.
REQ-016 In NORMAL, SHALL hold pipe_stall=0 and give a live pipe write priority, driving mc_ready=0.
REQ-017 In NORMAL with no live pipe write, SHALL drive mc_ready=mc_valid combinationally.
REQ-018 SHALL keep a starvation counter that increments each cycle mc_valid=1 and mc_ready=0, and clears on any accept.
REQ-019 SHALL move NORMAL->FORCE on the edge where the counter would reach STARVE_LIMIT.
REQ-020 In FORCE, SHALL drive pipe_stall=1 and mc_ready=mc_valid, and SHALL return to NORMAL on the next edge with the counter cleared.
REQ-021 In FORCE, SHALL not write pipe data; the held MEM/WB write SHALL be issued in the following NORMAL cycle.
REQ-022 SHALL register the granted write: rf_we, rf_rd and rf_wdata are valid exactly 1 cycle after the grant.
REQ-023 On an idle cycle, SHALL drive rf_we=0 and hold rf_rd and rf_wdata.
REQ-024 SHALL accept an mc result with mc_rd=0 (mc_ready=1) but SHALL discard it, driving rf_we=0.
REQ-025 SHALL require the multi-cycle unit to hold mc_valid, mc_rd and mc_wdata stable until mc_ready=1; behaviour otherwise is undefined.
REQ-026 If mc_valid drops while in FORCE, SHALL still return to NORMAL after one stall cycle with no write.
REQ-027 SHALL perform at most one register-file write per cycle.

Reset
REQ-028 On reset=0, SHALL immediately set: FSM=NORMAL, counter=0, rf_we=0, rf_rd=0, rf_wdata=0, pipe_stall=0.
REQ-029 On reset asserted mid-FORCE, SHALL drop any pending grant; a held mc_valid SHALL be re-arbitrated after reset release.
REQ-030 SHALL keep mc_ready=0 while reset=0.

Configuration
REQ-031 With macro WB_ARB_STATS_EN defined, SHALL add 32-bit output ports stat_mc_grants and stat_force_stalls.
REQ-032 With WB_ARB_STATS_EN defined, stat_mc_grants SHALL count accepted mc results, stat_force_stalls SHALL count FORCE cycles, both SHALL wrap at 2^32 and both SHALL reset to 0.
REQ-033 Without WB_ARB_STATS_EN, the stat ports and counters SHALL be absent, with behaviour otherwise identical.

Verification
REQ-034 SHALL cover: pipe_regwrite=1, pipe_rd=5, pipe_wdata=0xAA, mc idle -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xAA.
REQ-035 SHALL cover: pipe_regwrite=1, pipe_rd=0, mc_valid=1, mc_rd=7, mc_wdata=0x1234 -> mc_ready=1 same cycle; next cycle rf_rd=7, rf_wdata=0x1234.
REQ-036 SHALL cover: STARVE_LIMIT=4, live pipe writes every cycle, mc_valid held -> 4 blocked cycles, then 1 cycle with pipe_stall=1 and mc_ready=1, then the held pipe write is issued.
REQ-037 SHALL cover: mc_valid=1, mc_rd=0, no pipe write -> mc_ready=1 and rf_we=0 the next cycle.
REQ-038 SHALL cover: reset=0 asserted during FORCE -> pipe_stall=0 and rf_we=0 at once; after release, the held mc result is granted normally.
REQ-039 SHALL cover: with WB_ARB_STATS_EN defined, scenario REQ-036 -> stat_force_stalls=1 and stat_mc_grants=1.
